// File: rtl/exu_load_swc_unit.sv
// Load-instruction execute slice: reads rs1 during the EX phase (cycle_cnt==2)
// and registers a one-cycle load request for the memory access unit.
// Optional build macro: EXU_LOAD_MISALIGN_CHK_EN adds exu_load_misalign and
// suppresses exu_load_en for misaligned halfword/word accesses.
module exu_load_swc_unit (
  input  logic        hclk,
  input  logic        hrstn,
  input  logic [3:0]  cycle_cnt,
  input  logic        ifu_dec_stall,
  input  logic        dec_load_en,
  input  logic        dec_lb,
  input  logic        dec_lh,
  input  logic        dec_lw,
  input  logic        dec_lbu,
  input  logic        dec_lhu,
  input  logic [11:0] dec_imm_type_i,
  input  logic [4:0]  dec_rd,
  input  logic [4:0]  dec_rs1,
  output logic [4:0]  reg_raddr_1,
  output logic        reg_ren_1,
  input  logic [31:0] reg_rdata_1,
  output logic [4:0]  exu_load_rd,
  output logic [31:0] exu_load_base_addr,
  output logic [31:0] exu_load_offset,
  output logic        exu_load_sext,
  output logic [1:0]  exu_load_size,
  output logic        exu_load_en
`ifdef EXU_LOAD_MISALIGN_CHK_EN
  ,
  output logic        exu_load_misalign
`endif
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned IMM_W  = 12;
  localparam int unsigned TYPE_N = 5;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  logic [REG_AW-1:0] rd_q,     rd_d;
  logic [XLEN-1:0]   base_q,   base_d;
  logic [XLEN-1:0]   offset_q, offset_d;
  logic              sext_q,   sext_d;
  logic [1:0]        size_q,   size_d;
  logic              en_q,     en_d;

  logic [TYPE_N-1:0] type_vec;
  logic              type_valid;
  logic              rd_req;
  logic              issue;
  logic [XLEN-1:0]   offset_ext;
  logic [1:0]        size_sel;
  logic              misalign;

`ifdef EXU_LOAD_MISALIGN_CHK_EN
  logic              misalign_q, misalign_d;
  logic [1:0]        addr_lo;
`endif

  // Issue qualification: EX phase, not stalled, exactly one load type flag set
  always_comb begin
    type_vec   = {dec_lb, dec_lh, dec_lw, dec_lbu, dec_lhu};
    type_valid = (type_vec != '0) &&
                 ((type_vec & (type_vec - TYPE_N'(1))) == '0);
    rd_req     = dec_load_en && (cycle_cnt == 4'd2) && !ifu_dec_stall;
    issue      = rd_req && type_valid;
    offset_ext = {{(XLEN-IMM_W){dec_imm_type_i[IMM_W-1]}}, dec_imm_type_i};
    if (dec_lw) begin
      size_sel = SIZE_WORD;
    end else if (dec_lh || dec_lhu) begin
      size_sel = SIZE_HALF;
    end else begin
      size_sel = SIZE_BYTE;
    end
  end

  // Regfile read port is driven straight from the decode/phase inputs
  always_comb begin
    reg_ren_1   = rd_req;
    reg_raddr_1 = rd_req ? dec_rs1 : REG_AW'(0);
  end

`ifdef EXU_LOAD_MISALIGN_CHK_EN
  // Only the two low address bits matter for alignment
  always_comb begin
    addr_lo  = reg_rdata_1[1:0] + offset_ext[1:0];
    misalign = ((size_sel == SIZE_HALF) && addr_lo[0]) ||
               ((size_sel == SIZE_WORD) && (addr_lo != 2'b00));
  end
`else
  assign misalign = 1'b0;
`endif

  // Request capture: fields hold between requests, strobe is a single pulse
  always_comb begin
    rd_d     = rd_q;
    base_d   = base_q;
    offset_d = offset_q;
    sext_d   = sext_q;
    size_d   = size_q;
    en_d     = 1'b0;
`ifdef EXU_LOAD_MISALIGN_CHK_EN
    misalign_d = 1'b0;
`endif
    if (issue) begin
      rd_d     = dec_rd;
      base_d   = reg_rdata_1;
      offset_d = offset_ext;
      sext_d   = dec_lb || dec_lh;
      size_d   = size_sel;
      en_d     = !misalign;
`ifdef EXU_LOAD_MISALIGN_CHK_EN
      misalign_d = misalign;
`endif
    end
  end

  // Request registers, cleared asynchronously
  always_ff @(posedge hclk or posedge hrstn) begin
    if (hrstn) begin
      rd_q     <= '0;
      base_q   <= '0;
      offset_q <= '0;
      sext_q   <= 1'b0;
      size_q   <= SIZE_BYTE;
      en_q     <= 1'b0;
`ifdef EXU_LOAD_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      rd_q     <= rd_d;
      base_q   <= base_d;
      offset_q <= offset_d;
      sext_q   <= sext_d;
      size_q   <= size_d;
      en_q     <= en_d;
`ifdef EXU_LOAD_MISALIGN_CHK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign exu_load_rd        = rd_q;
  assign exu_load_base_addr = base_q;
  assign exu_load_offset    = offset_q;
  assign exu_load_sext      = sext_q;
  assign exu_load_size      = size_q;
  assign exu_load_en        = en_q;
`ifdef EXU_LOAD_MISALIGN_CHK_EN
  assign exu_load_misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_exu_load_swc_unit.sv
// Directed bench for exu_load_swc_unit; the bench drives the phase counter.
module tb_exu_load_swc_unit;

  logic        hclk = 1'b0;
  logic        hrstn;
  logic [3:0]  cycle_cnt;
  logic        ifu_dec_stall;
  logic        dec_load_en;
  logic        dec_lb, dec_lh, dec_lw, dec_lbu, dec_lhu;
  logic [11:0] dec_imm_type_i;
  logic [4:0]  dec_rd, dec_rs1;
  logic [4:0]  reg_raddr_1;
  logic        reg_ren_1;
  logic [31:0] reg_rdata_1;
  logic [4:0]  exu_load_rd;
  logic [31:0] exu_load_base_addr;
  logic [31:0] exu_load_offset;
  logic        exu_load_sext;
  logic [1:0]  exu_load_size;
  logic        exu_load_en;
`ifdef EXU_LOAD_MISALIGN_CHK_EN
  logic        exu_load_misalign;
`endif

  int n_cmp = 0;
  int n_err = 0;

  exu_load_swc_unit dut (
    .hclk               (hclk),
    .hrstn              (hrstn),
    .cycle_cnt          (cycle_cnt),
    .ifu_dec_stall      (ifu_dec_stall),
    .dec_load_en        (dec_load_en),
    .dec_lb             (dec_lb),
    .dec_lh             (dec_lh),
    .dec_lw             (dec_lw),
    .dec_lbu            (dec_lbu),
    .dec_lhu            (dec_lhu),
    .dec_imm_type_i     (dec_imm_type_i),
    .dec_rd             (dec_rd),
    .dec_rs1            (dec_rs1),
    .reg_raddr_1        (reg_raddr_1),
    .reg_ren_1          (reg_ren_1),
    .reg_rdata_1        (reg_rdata_1),
    .exu_load_rd        (exu_load_rd),
    .exu_load_base_addr (exu_load_base_addr),
    .exu_load_offset    (exu_load_offset),
    .exu_load_sext      (exu_load_sext),
    .exu_load_size      (exu_load_size),
    .exu_load_en        (exu_load_en)
`ifdef EXU_LOAD_MISALIGN_CHK_EN
    ,
    .exu_load_misalign  (exu_load_misalign)
`endif
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the phase counter moves just after the edge
  task automatic next_cycle();
    @(posedge hclk);
    #1;
    cycle_cnt = (cycle_cnt == 4'd4 || cycle_cnt == 4'd0) ? 4'd1 : cycle_cnt + 4'd1;
    #1;
  endtask

  // Advance until the counter reaches the wanted phase, bounded
  task automatic goto_cc(input logic [3:0] target);
    int k;
    k = 0;
    next_cycle();
    while (cycle_cnt != target && k < 8) begin
      next_cycle();
      k++;
    end
    chk("goto_phase", 32'(cycle_cnt), 32'(target));
  endtask

  task automatic set_type(input logic lb, lh, lw, lbu, lhu);
    dec_lb = lb; dec_lh = lh; dec_lw = lw; dec_lbu = lbu; dec_lhu = lhu;
  endtask

  task automatic chk_req(input string tag, input logic [4:0] rd, input logic [31:0] base,
                         input logic [31:0] off, input logic sext, input logic [1:0] size,
                         input logic en);
    chk({tag, "_rd"},   32'(exu_load_rd),        32'(rd));
    chk({tag, "_base"}, exu_load_base_addr,      base);
    chk({tag, "_off"},  exu_load_offset,         off);
    chk({tag, "_sext"}, 32'(exu_load_sext),      32'(sext));
    chk({tag, "_size"}, 32'(exu_load_size),      32'(size));
    chk({tag, "_en"},   32'(exu_load_en),        32'(en));
  endtask

  initial begin
    hrstn = 1'b1;
    cycle_cnt = 4'd2;
    ifu_dec_stall = 1'b0;
    dec_load_en = 1'b1;
    set_type(0, 0, 1, 0, 0);
    dec_imm_type_i = 12'd4;
    dec_rd = 5'd1;
    dec_rs1 = 5'd3;
    reg_rdata_1 = 32'h0000_0100;
    #3;
    // Reset: registers clear, combinational read port follows inputs
    chk_req("rst", 5'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0);
    chk("rst_ren", 32'(reg_ren_1), 32'd1);
    chk("rst_raddr", 32'(reg_raddr_1), 32'd3);
    @(posedge hclk); #1;
    chk("rst_hold_en", 32'(exu_load_en), 32'd0);
    chk("rst_hold_rd", 32'(exu_load_rd), 32'd0);
    cycle_cnt = 4'd0;
    dec_load_en = 1'b0;
    set_type(0, 0, 0, 0, 0);
    @(posedge hclk); #1;
    hrstn = 1'b0;

    // Test 1: lb imm=10 rd=5 rs1=2 base=2
    dec_load_en = 1'b1;
    set_type(1, 0, 0, 0, 0);
    dec_imm_type_i = 12'd10;
    dec_rd = 5'd5;
    dec_rs1 = 5'd2;
    reg_rdata_1 = 32'd2;
    goto_cc(4'd1);
    chk("cc1_ren", 32'(reg_ren_1), 32'd0);
    chk("cc1_raddr", 32'(reg_raddr_1), 32'd0);
    goto_cc(4'd2);
    chk("cc2_ren", 32'(reg_ren_1), 32'd1);
    chk("cc2_raddr", 32'(reg_raddr_1), 32'd2);
    chk("cc2_en", 32'(exu_load_en), 32'd0);
    goto_cc(4'd3);
    chk_req("lb", 5'd5, 32'd2, 32'd10, 1'b1, 2'b00, 1'b1);
    goto_cc(4'd4);
    chk("lb_pulse_end", 32'(exu_load_en), 32'd0);
    goto_cc(4'd3);
    chk("lb_repeat_en", 32'(exu_load_en), 32'd1);

    // Test 2: lhu, then lw
    set_type(0, 0, 0, 0, 1);
    goto_cc(4'd3);
    chk_req("lhu", 5'd5, 32'd2, 32'd10, 1'b0, 2'b01, 1'b1);
    set_type(0, 0, 1, 0, 0);
    goto_cc(4'd3);
    chk_req("lw", 5'd5, 32'd2, 32'd10, 1'b0, 2'b10, 1'b1);

    // Test 3: immediate sign extension
    set_type(0, 0, 0, 1, 0);
    dec_rd = 5'd17;
    reg_rdata_1 = 32'h1000_0000;
    dec_imm_type_i = 12'hFFF;
    goto_cc(4'd3);
    chk_req("imm_fff", 5'd17, 32'h1000_0000, 32'hFFFF_FFFF, 1'b0, 2'b00, 1'b1);
    set_type(0, 0, 1, 0, 0);
    dec_imm_type_i = 12'h800;
    goto_cc(4'd3);
    chk_req("imm_800", 5'd17, 32'h1000_0000, 32'hFFFF_F800, 1'b0, 2'b10, 1'b1);

    // Test 4: stall across the EX phase
    dec_rd = 5'd9;
    reg_rdata_1 = 32'h0000_0040;
    goto_cc(4'd1);
    ifu_dec_stall = 1'b1;
    goto_cc(4'd2);
    chk("stall_ren", 32'(reg_ren_1), 32'd0);
    chk("stall_raddr", 32'(reg_raddr_1), 32'd0);
    goto_cc(4'd3);
    chk_req("stall", 5'd17, 32'h1000_0000, 32'hFFFF_F800, 1'b0, 2'b10, 1'b0);
    ifu_dec_stall = 1'b0;
    goto_cc(4'd3);
    chk_req("post_stall", 5'd9, 32'h0000_0040, 32'hFFFF_F800, 1'b0, 2'b10, 1'b1);

    // Test 5: invalid flag combinations and no load
    dec_rd = 5'd20;
    set_type(1, 0, 1, 0, 0);
    goto_cc(4'd2);
    chk("multi_ren", 32'(reg_ren_1), 32'd1);
    chk("multi_raddr", 32'(reg_raddr_1), 32'd2);
    goto_cc(4'd3);
    chk("multi_en", 32'(exu_load_en), 32'd0);
    chk("multi_rd_hold", 32'(exu_load_rd), 32'd9);
    set_type(0, 0, 0, 0, 0);
    goto_cc(4'd3);
    chk("none_en", 32'(exu_load_en), 32'd0);
    set_type(0, 0, 1, 0, 0);
    dec_load_en = 1'b0;
    goto_cc(4'd2);
    chk("noload_ren", 32'(reg_ren_1), 32'd0);
    chk("noload_raddr", 32'(reg_raddr_1), 32'd0);
    goto_cc(4'd3);
    chk("noload_en", 32'(exu_load_en), 32'd0);
    chk("noload_rd_hold", 32'(exu_load_rd), 32'd9);

    // Test 6: reset during the pulse
    dec_load_en = 1'b1;
    set_type(1, 0, 0, 0, 0);
    dec_rd = 5'd7;
    dec_imm_type_i = 12'd3;
    goto_cc(4'd3);
    chk("pre_rst_en", 32'(exu_load_en), 32'd1);
    hrstn = 1'b1;
    #1;
    chk_req("mid_rst", 5'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0);
    cycle_cnt = 4'd0;
    @(posedge hclk); #1;
    hrstn = 1'b0;
    goto_cc(4'd2);
    chk("after_rst_cc2_en", 32'(exu_load_en), 32'd0);
    goto_cc(4'd3);
    chk_req("after_rst", 5'd7, 32'h0000_0040, 32'd3, 1'b1, 2'b00, 1'b1);

`ifdef EXU_LOAD_MISALIGN_CHK_EN
    // Misaligned word: base=2, offset=0
    set_type(0, 0, 1, 0, 0);
    reg_rdata_1 = 32'd2;
    dec_imm_type_i = 12'd0;
    goto_cc(4'd3);
    chk("mis_flag", 32'(exu_load_misalign), 32'd1);
    chk("mis_en", 32'(exu_load_en), 32'd0);
    goto_cc(4'd4);
    chk("mis_flag_end", 32'(exu_load_misalign), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exu_load_swc_unit.md
Name: exu_load_swc_unit

Overview:
Load-instruction execute slice of the switch-MCU core's EXU. It reads the base register (rs1) from the register file during the EX slot of the core's 4-phase cycle counter. It then registers a load request for the memory access unit (MAU): destination register, base address, sign-extended I-type offset, access size and sign-extension flag. The request is presented with a one-cycle enable pulse.

Parameters:
None. All widths are fixed: XLEN=32, 5-bit register index, 12-bit immediate.

Ports:
hclk  input  1  core clock, rising edge
hrstn  input  1  asynchronous reset, active-high (legacy name kept; asserted = 1)
cycle_cnt  input  4  core phase counter: 0 after reset, then 1,2,3,4,1,...
ifu_dec_stall  input  1  pipeline stall; blocks issue
dec_load_en  input  1  decoded instruction is a load
dec_lb / dec_lh / dec_lw / dec_lbu / dec_lhu  input  1 each  load-type flags (one-hot)
dec_imm_type_i  input  12  I-type immediate
dec_rd  input  5  destination register
dec_rs1  input  5  base register
reg_raddr_1  output  5  regfile read address, port 1
reg_ren_1  output  1  regfile read enable, port 1
reg_rdata_1  input  32  regfile read data (combinational, same cycle as ren)
exu_load_rd  output  5  MAU destination register
exu_load_base_addr  output  32  rs1 value
exu_load_offset  output  32  sign-extended immediate
exu_load_sext  output  1  1 = sign-extend loaded data
exu_load_size  output  2  00 byte, 01 half, 10 word
exu_load_en  output  1  MAU request strobe

Behaviour:
- Define issue = dec_load_en & (cycle_cnt==2) & !ifu_dec_stall & valid, where valid = exactly one of the five type flags is set.
- reg_ren_1 is combinational: dec_load_en & (cycle_cnt==2) & !ifu_dec_stall.
- reg_raddr_1 = dec_rs1 when reg_ren_1=1, otherwise 5'd0.
- On the rising edge that ends a cycle where issue=1, register:
  - exu_load_rd <= dec_rd
  - exu_load_base_addr <= reg_rdata_1
  - exu_load_offset <= {{20{imm[11]}}, imm}
  - exu_load_sext <= dec_lb | dec_lh
  - exu_load_size <= 00 for lb/lbu, 01 for lh/lhu, 10 for lw
  - exu_load_en <= 1
- Outputs therefore become valid in the cycle where cycle_cnt==3.
- On any other edge: exu_load_en <= 0. All other outputs hold their last value; no clearing between requests.
- exu_load_en is therefore a single-cycle pulse, at most once per 4-cycle round.
- Stall during cycle_cnt==2: no regfile read and no capture. exu_load_en stays 0 for that round. The request is not retried later in the same round.
- Invalid flags (zero or multiple set) with dec_load_en=1: the regfile read still happens, but nothing is captured and exu_load_en stays 0.
- cycle_cnt values 0, 1, 3, 4 never issue.
- Reset (asynchronous, active-high):
  - All registered outputs clear to 0 immediately: exu_load_rd, base_addr, offset, sext, size, exu_load_en.
  - Reset asserted mid-round drops any pending pulse.
  - Combinational outputs follow their inputs during reset.
- Size encoding 11 is never produced.

Optional Feature:
Macro EXU_LOAD_MISALIGN_CHK_EN.
- Defined:
  - Adds output exu_load_misalign (1 bit), registered alongside the request.
  - It is set when (base+offset)[0]=1 for a halfword access, or (base+offset)[1:0]!=0 for a word access.
  - When misaligned: exu_load_misalign pulses with the request, and exu_load_en is suppressed.
  - Reset value 0.
- Not defined: the port does not exist, and every valid load issues regardless of alignment.

Test Plan:
1. Reset, then lb with imm=10, rd=5, rs1=2, reg_rdata_1=2 -> at cycle_cnt==2: reg_ren_1=1, reg_raddr_1=2. Next cycle: exu_load_en=1, rd=5, base=2, offset=10, sext=1, size=00. Pulse repeats every 4 cycles.
2. Switch to lhu with the same operands -> sext=0, size=01, other fields unchanged. lw -> size=10, sext=0.
3. imm=12'hFFF, then 12'h800 -> offset 32'hFFFFFFFF, then 32'hFFFFF800.
4. ifu_dec_stall=1 throughout cycle_cnt==2 -> reg_ren_1=0, no exu_load_en pulse, outputs hold previous values. The following round issues normally.
5. dec_lb=dec_lw=1, or no flag set -> exu_load_en never pulses. dec_load_en=0 -> reg_ren_1=0, reg_raddr_1=0.
6. Assert hrstn=1 during the exu_load_en pulse -> all registered outputs read 0 immediately. After release, the next issue occurs at the next cycle_cnt==2. With the misalignment macro defined: lw with base=2, offset=0 -> exu_load_misalign=1 and exu_load_en=0.
